// File: rtl/slant_stream_tx.sv
// slant_stream_tx: streams a V_ACTIVE x H_ACTIVE frame from frame memory as AXI4-Stream video.
// Optional colour-bar generator, enabled by `define SLANT_STREAM_TX_TPG_EN (adds pattern_sel).
module slant_stream_tx #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int HBLANK   = 4
) (
   input  logic        Cclk,
   input  logic        rstn,
   input  logic        start,
   output logic        busy,
   output logic        frame_done,
   output logic        mem_rd_en,
   output logic [18:0] mem_rd_addr,
   input  logic [9:0]  mem_rd_data,
`ifdef SLANT_STREAM_TX_TPG_EN
   input  logic        pattern_sel,
`endif
   output logic [23:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   input  logic        m_axis_video_tready,
   output logic        m_axis_video_tuser,
   output logic        m_axis_video_tlast
);

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam int GW = $clog2(HBLANK + 1);
   localparam int EW = 26;

   typedef enum logic [1:0] {IDLE, LINE, GAP, DONE} state_t;
   state_t state_reg, state_next;

   logic [XW-1:0] x_reg;
   logic [YW-1:0] y_reg;
   logic [GW-1:0] gap_reg;
   logic [18:0]   addr_reg;
   logic          inflight_reg, inf_user_reg, inf_last_reg;
   logic [1:0]    count_reg;
   logic          wr_ptr_reg, rd_ptr_reg;
   logic [EW-1:0] fifo_mem [2];
   logic [EW-1:0] in_word, head_word;
   logic [2:0]    used;
   logic          rd_issue, pop, tvalid, line_end, frame_end, tpg_mode;

`ifdef SLANT_STREAM_TX_TPG_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic          tpg_mode_reg;
   logic [2:0]    inf_bar_reg;
   logic [XW-1:0] bar_full;
   logic [7:0]    bar_y;
   assign bar_full = x_reg / XW'(BAR_W);
   assign bar_y    = 8'hE0 - {inf_bar_reg, 5'b00000};
   assign tpg_mode = tpg_mode_reg;
`else
   assign tpg_mode = 1'b0;
`endif

   assign line_end  = (x_reg == XW'(H_ACTIVE - 1));
   assign frame_end = line_end && (y_reg == YW'(V_ACTIVE - 1));

   // Output stage falls through: a word arriving from memory is visible the same cycle
   // when the FIFO is empty, giving start-to-tvalid latency of two edges.
   assign tvalid = (count_reg != 2'd0) || inflight_reg;
   assign pop    = tvalid && m_axis_video_tready;

   always_comb begin
      in_word = {8'h00, mem_rd_data[9:5], 3'b000, mem_rd_data[4:0], 3'b000,
                 inf_user_reg, inf_last_reg};
`ifdef SLANT_STREAM_TX_TPG_EN
      if (tpg_mode_reg)
         in_word = {8'h00, 8'h80, bar_y, inf_user_reg, inf_last_reg};
`endif
   end

   always_comb begin
      if (count_reg != 2'd0)
         head_word = fifo_mem[rd_ptr_reg];
      else if (inflight_reg)
         head_word = in_word;
      else
         head_word = '0;
   end

   always_ff @(posedge Cclk or negedge rstn) begin
      if (!rstn)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Occupancy after this edge; a read issued now lands one cycle later, so it must fit.
   always_comb begin
      state_next = state_reg;
      used       = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
      rd_issue   = (state_reg == LINE) && (used < 3'd2);
      frame_done = (state_reg == DONE) && pop &&
                   ((3'(count_reg) + 3'(inflight_reg)) == 3'd1);
      case (state_reg)
         IDLE:    if (start) state_next = LINE;
         LINE:    if (rd_issue && line_end) state_next = frame_end ? DONE : GAP;
         GAP:     if (gap_reg == GW'(HBLANK - 1)) state_next = LINE;
         DONE:    if (frame_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Cclk or negedge rstn) begin
      if (!rstn) begin
         x_reg        <= '0;
         y_reg        <= '0;
         gap_reg      <= '0;
         addr_reg     <= '0;
         inflight_reg <= 1'b0;
         inf_user_reg <= 1'b0;
         inf_last_reg <= 1'b0;
         count_reg    <= '0;
         wr_ptr_reg   <= 1'b0;
         rd_ptr_reg   <= 1'b0;
`ifdef SLANT_STREAM_TX_TPG_EN
         tpg_mode_reg <= 1'b0;
         inf_bar_reg  <= '0;
`endif
      end else begin
         inflight_reg <= rd_issue;
         inf_user_reg <= rd_issue && (x_reg == '0) && (y_reg == '0);
         inf_last_reg <= rd_issue && line_end;
         count_reg    <= used[1:0];
         if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)          rd_ptr_reg <= ~rd_ptr_reg;
         gap_reg <= (state_reg == GAP) ? gap_reg + 1'b1 : '0;
`ifdef SLANT_STREAM_TX_TPG_EN
         inf_bar_reg <= 3'(bar_full);
`endif
         if (state_reg == IDLE && start) begin
            addr_reg <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
`ifdef SLANT_STREAM_TX_TPG_EN
            tpg_mode_reg <= pattern_sel;
`endif
         end else if (rd_issue) begin
            addr_reg <= addr_reg + 19'd1;
            if (line_end) begin
               x_reg <= '0;
               y_reg <= y_reg + 1'b1;
            end else begin
               x_reg <= x_reg + 1'b1;
            end
         end
      end
   end

   // Every arriving word is written; when it is consumed by bypass the read pointer skips it.
   always_ff @(posedge Cclk) begin
      if (inflight_reg)
         fifo_mem[wr_ptr_reg] <= in_word;
   end

   assign busy                = (state_reg != IDLE);
   assign mem_rd_en           = rd_issue && !tpg_mode;
   assign mem_rd_addr         = addr_reg;
   assign m_axis_video_tvalid = tvalid;
   assign m_axis_video_tdata  = head_word[25:2];
   assign m_axis_video_tuser  = head_word[1];
   assign m_axis_video_tlast  = head_word[0];

endmodule

// File: tb/tb_slant_stream_tx.sv
// Directed bench for slant_stream_tx (H_ACTIVE=4, V_ACTIVE=2, HBLANK=2; H_ACTIVE=16 with
// SLANT_STREAM_TX_TPG_EN defined, where only the reset and colour-bar scenarios run).
`timescale 1ns/1ps
module tb_slant_stream_tx;
`ifdef SLANT_STREAM_TX_TPG_EN
   localparam int H_ACT = 16;
`else
   localparam int H_ACT = 4;
`endif
   localparam int V_ACT = 2;
   localparam int NB    = H_ACT * V_ACT;

   logic        Cclk = 1'b0, rstn = 1'b0, start = 1'b0, tready = 1'b1;
   logic        busy, frame_done, mem_rd_en, tvalid, tuser, tlast;
   logic [18:0] mem_rd_addr;
   logic [9:0]  mem_rd_data = '0;
   logic [23:0] tdata;
`ifdef SLANT_STREAM_TX_TPG_EN
   logic        pattern_sel = 1'b0;
`endif

   logic [9:0] mem_img [32];
   int cyc = 0, checks = 0, failures = 0;

   typedef struct {logic [23:0] d; logic u; logic l; int c;} beat_t;
   beat_t beats[$];
   int    rd_addrs[$];
   int    done_cycs[$];
   int    stab_err = 0, ovf_err = 0, issued = 0, accepted = 0;
   logic        prev_stall = 1'b0;
   logic [25:0] prev_word = '0;

   slant_stream_tx #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .HBLANK(2)) dut (
      .Cclk(Cclk), .rstn(rstn), .start(start), .busy(busy), .frame_done(frame_done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
`ifdef SLANT_STREAM_TX_TPG_EN
      .pattern_sel(pattern_sel),
`endif
      .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
      .m_axis_video_tready(tready), .m_axis_video_tuser(tuser),
      .m_axis_video_tlast(tlast));

   always #5 Cclk = ~Cclk;
   always @(posedge Cclk) cyc <= cyc + 1;
   always @(posedge Cclk) if (mem_rd_en) mem_rd_data <= mem_img[mem_rd_addr[4:0]];

   // Observer: logs reads, accepted beats and frame_done; tracks stall stability and occupancy.
   always @(negedge Cclk) begin
      if (!rstn) begin
         issued = 0; accepted = 0; prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!tvalid || {tdata, tuser, tlast} !== prev_word)) stab_err++;
         prev_stall = tvalid && !tready;
         prev_word  = {tdata, tuser, tlast};
         if (mem_rd_en) begin rd_addrs.push_back(int'(mem_rd_addr)); issued++; end
         if (tvalid && tready) begin
            beats.push_back('{tdata, tuser, tlast, cyc});
            accepted++;
         end
         if (frame_done) done_cycs.push_back(cyc);
         if (issued - accepted > 2) ovf_err++;
      end
   end

   function automatic logic [23:0] fmt(input logic [9:0] v);
      return {8'h00, v[9:5], 3'b000, v[4:0], 3'b000};
   endfunction

   task automatic clear_logs();
      beats.delete(); rd_addrs.delete(); done_cycs.delete();
      stab_err = 0; ovf_err = 0;
   endtask

   task automatic pulse_start(output int s);
      @(posedge Cclk); #1;
      start = 1'b1; s = cyc;
      @(posedge Cclk); #1;
      start = 1'b0;
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin @(posedge Cclk); #1; end
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_cycs.size() == 0 && n < limit) begin @(posedge Cclk); n++; end
      #1;
      checks++;
      if (done_cycs.size() == 0) begin
         failures++;
         $display("FAIL frame_done_timeout: no frame_done within %0d cycles, required 1", limit);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge Cclk);
      checks++;
      if ({busy, frame_done, mem_rd_en, tvalid, tuser, tlast} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: busy/done/rd_en/tvalid/tuser/tlast=%b required 000000",
                  {busy, frame_done, mem_rd_en, tvalid, tuser, tlast});
      end
      checks++;
      if (mem_rd_addr !== 19'd0) begin
         failures++; $display("FAIL reset_addr: got %0h required 0", mem_rd_addr);
      end
      checks++;
      if (tdata !== 24'h0) begin
         failures++; $display("FAIL reset_tdata: got %h required 000000", tdata);
      end
      @(posedge Cclk); #1; rstn = 1'b1;
      repeat (2) @(posedge Cclk); #1;
   endtask

   task automatic test_basic();
      int s;
      clear_logs(); tready = 1'b1;
      pulse_start(s);
      wait_done(100);
      checks++;
      if (rd_addrs.size() != NB) begin
         failures++; $display("FAIL basic_nreads: got %0d required %0d", rd_addrs.size(), NB);
      end
      for (int k = 0; k < rd_addrs.size() && k < NB; k++) begin
         checks++;
         if (rd_addrs[k] != k) begin
            failures++; $display("FAIL basic_addr[%0d]: got %0d required %0d", k, rd_addrs[k], k);
         end
      end
      checks++;
      if (beats.size() != NB) begin
         failures++; $display("FAIL basic_nbeats: got %0d required %0d", beats.size(), NB);
      end
      for (int k = 0; k < beats.size() && k < NB; k++) begin
         checks++;
         if ({beats[k].d, beats[k].u, beats[k].l} !==
             {fmt(mem_img[k]), k == 0, (k % H_ACT) == H_ACT - 1}) begin
            failures++;
            $display("FAIL basic_beat[%0d]: got d=%h u=%b l=%b required d=%h u=%b l=%b", k,
                     beats[k].d, beats[k].u, beats[k].l, fmt(mem_img[k]), k == 0,
                     (k % H_ACT) == H_ACT - 1);
         end
      end
      if (beats.size() == NB && done_cycs.size() > 0) begin
         checks++;
         if (beats[0].c != s + 2) begin
            failures++; $display("FAIL basic_latency: first beat cycle %0d required %0d",
                                 beats[0].c, s + 2);
         end
         checks++;
         if (beats[4].c - beats[3].c - 1 != 2) begin
            failures++; $display("FAIL basic_hblank: idle cycles %0d required 2",
                                 beats[4].c - beats[3].c - 1);
         end
         checks++;
         if (done_cycs[0] != beats[7].c) begin
            failures++; $display("FAIL basic_done_cycle: got %0d required %0d",
                                 done_cycs[0], beats[7].c);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL basic_busy_after: got %b required 0", busy);
      end
   endtask

   task automatic test_backpressure();
      int s, n;
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < NB; k++) mem_img[k] = 10'(k * 77 + 13);
      clear_logs(); tready = 1'b1;
      pulse_start(s);
      n = 0;
      while (done_cycs.size() == 0 && n < 300) begin
         @(posedge Cclk); #1; tready = pat[cyc % 4]; n++;
      end
      tready = 1'b1;
      repeat (2) @(posedge Cclk); #1;
      checks++;
      if (beats.size() != NB) begin
         failures++; $display("FAIL bp_nbeats: got %0d required %0d", beats.size(), NB);
      end
      for (int k = 0; k < beats.size() && k < NB; k++) begin
         checks++;
         if ({beats[k].d, beats[k].u, beats[k].l} !==
             {fmt(mem_img[k]), k == 0, (k % H_ACT) == H_ACT - 1}) begin
            failures++;
            $display("FAIL bp_beat[%0d]: got d=%h u=%b l=%b required d=%h", k,
                     beats[k].d, beats[k].u, beats[k].l, fmt(mem_img[k]));
         end
      end
      checks++;
      if (stab_err != 0) begin
         failures++; $display("FAIL bp_stall_stable: %0d changes under stall, required 0", stab_err);
      end
      checks++;
      if (ovf_err != 0) begin
         failures++; $display("FAIL bp_inflight: %0d overruns, required 0", ovf_err);
      end
      checks++;
      if (done_cycs.size() != 1) begin
         failures++; $display("FAIL bp_done_count: got %0d required 1", done_cycs.size());
      end
      for (int k = 0; k < 32; k++) mem_img[k] = 10'(k);
   endtask

   task automatic test_start_ignore();
      int s, s2;
      clear_logs(); tready = 1'b1;
      pulse_start(s);
      goto(s + 4); start = 1'b1;
      goto(s + 5); start = 1'b0;
      goto(s + 11); start = 1'b1;
      goto(s + 12); start = 1'b0;
      checks++;
      if (done_cycs.size() != 1 || (done_cycs.size() == 1 && done_cycs[0] != s + 11)) begin
         failures++; $display("FAIL ign_done_cycle: count=%0d required one pulse at %0d",
                              done_cycs.size(), s + 11);
      end
      checks++;
      if (rd_addrs.size() != NB || (rd_addrs.size() == NB && rd_addrs[NB-1] != NB - 1)) begin
         failures++; $display("FAIL ign_reads: count=%0d required %0d ending at %0d",
                              rd_addrs.size(), NB, NB - 1);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL ign_busy: got %b required 0 after start at frame_done", busy);
      end
      clear_logs();
      start = 1'b1; s2 = cyc;
      goto(s2 + 1); start = 1'b0;
      @(negedge Cclk);
      checks++;
      if ({mem_rd_en, mem_rd_addr} !== {1'b1, 19'd0}) begin
         failures++; $display("FAIL ign_restart: rd_en=%b addr=%0d required rd_en=1 addr=0",
                              mem_rd_en, mem_rd_addr);
      end
      wait_done(100);
      checks++;
      if (beats.size() != NB) begin
         failures++; $display("FAIL ign_frame2_beats: got %0d required %0d", beats.size(), NB);
      end
   endtask

   task automatic test_format();
      int s;
      mem_img[0] = 10'b10101_00011;
      clear_logs(); tready = 1'b1;
      pulse_start(s);
      wait_done(100);
      checks++;
      if (beats.size() == 0 || beats[0].d !== 24'h00A818) begin
         failures++; $display("FAIL format: got %h required 00A818",
                              beats.size() > 0 ? beats[0].d : 24'hx);
      end
      mem_img[0] = 10'd0;
   endtask

   task automatic test_reset_midframe();
      int s;
      clear_logs(); tready = 1'b1;
      pulse_start(s);
      goto(s + 6);
      rstn = 1'b0;
      @(negedge Cclk);
      checks++;
      if ({busy, frame_done, mem_rd_en, tvalid, tuser, tlast} !== 6'b0 ||
          mem_rd_addr !== 19'd0 || tdata !== 24'h0) begin
         failures++;
         $display("FAIL midreset_outputs: ctrl=%b addr=%0d tdata=%h required all zero",
                  {busy, frame_done, mem_rd_en, tvalid, tuser, tlast}, mem_rd_addr, tdata);
      end
      goto(s + 7); rstn = 1'b1;
      repeat (2) @(posedge Cclk); #1;
      clear_logs();
      pulse_start(s);
      wait_done(100);
      checks++;
      if (rd_addrs.size() != NB || (rd_addrs.size() == NB && rd_addrs[0] != 0)) begin
         failures++; $display("FAIL midreset_reads: count=%0d required %0d from 0",
                              rd_addrs.size(), NB);
      end
      checks++;
      if (beats.size() != NB) begin
         failures++; $display("FAIL midreset_nbeats: got %0d required %0d", beats.size(), NB);
      end
      for (int k = 0; k < beats.size() && k < NB; k++) begin
         checks++;
         if ({beats[k].d, beats[k].u, beats[k].l} !==
             {fmt(mem_img[k]), k == 0, (k % H_ACT) == H_ACT - 1}) begin
            failures++; $display("FAIL midreset_beat[%0d]: got d=%h required d=%h", k,
                                 beats[k].d, fmt(mem_img[k]));
         end
      end
   endtask

`ifdef SLANT_STREAM_TX_TPG_EN
   task automatic test_tpg();
      int s;
      logic [7:0] ybar [8] = '{8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h60, 8'h40, 8'h20, 8'h00};
      clear_logs(); tready = 1'b1; pattern_sel = 1'b1;
      pulse_start(s);
      pattern_sel = 1'b0;
      wait_done(300);
      checks++;
      if (rd_addrs.size() != 0) begin
         failures++; $display("FAIL tpg_no_reads: got %0d reads required 0", rd_addrs.size());
      end
      checks++;
      if (beats.size() != NB) begin
         failures++; $display("FAIL tpg_nbeats: got %0d required %0d", beats.size(), NB);
      end
      for (int k = 0; k < beats.size() && k < NB; k++) begin
         checks++;
         if ({beats[k].d, beats[k].u, beats[k].l} !==
             {8'h00, 8'h80, ybar[(k % H_ACT) / 2], k == 0, (k % H_ACT) == H_ACT - 1}) begin
            failures++; $display("FAIL tpg_beat[%0d]: got d=%h required d=%h", k,
                                 beats[k].d, {8'h00, 8'h80, ybar[(k % H_ACT) / 2]});
         end
      end
   endtask
`endif

   initial begin
      for (int k = 0; k < 32; k++) mem_img[k] = 10'(k);
      test_reset();
`ifdef SLANT_STREAM_TX_TPG_EN
      test_tpg();
`else
      test_basic();
      test_backpressure();
      test_start_ignore();
      test_format();
      test_reset_midframe();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200us");
      $fatal(1);
   end

endmodule

// File: doc/slant_stream_tx.md
SLANT_STREAM_TX -- requirements
Module: slant_stream_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, giving active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, giving active lines per frame.
REQ-003 SHALL have parameter HBLANK, default 4, giving idle cycles (tvalid low) between lines.
REQ-004 SHALL have port Cclk, input, 1 bit: clock, all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to transmit one frame.
REQ-007 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-008 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last beat is accepted.
REQ-009 SHALL have port mem_rd_en, output, 1 bit: frame-memory read strobe.
REQ-010 SHALL have port mem_rd_addr, output, 19 bits: linear pixel address, row*H_ACTIVE+x.
REQ-011 SHALL have port mem_rd_data, input, 10 bits: {C[4:0],Y[4:0]}, valid exactly 1 cycle after mem_rd_en.
REQ-012 SHALL have ports m_axis_video_tdata (output, 24 bits), tvalid (output, 1 bit), tready (input, 1 bit), tuser (output, 1 bit) and tlast (output, 1 bit): AXI4-Stream video master.
REQ-013 SHALL have port pattern_sel, input, 1 bit, present only under TPG_EN.

Function
REQ-014 SHALL use a state machine with states IDLE, LINE, GAP and DONE: IDLE->LINE on start; LINE->GAP when the last read of a line is issued and lines remain; GAP->LINE after HBLANK cycles; LINE->DONE when the last read of the frame is issued; DONE->IDLE when the last beat is accepted.
REQ-015 SHALL ignore start while busy=1.
REQ-016 SHALL reset mem_rd_addr to 0 on an accepted start and increment it by 1 per issued read, with no wrap within a frame.
REQ-017 SHALL buffer data in a 2-entry output FIFO, each entry holding {tdata,tuser,tlast}.
REQ-018 SHALL assert mem_rd_en only in LINE, and only when occupancy+inflight-(tvalid&&tready) < 2, sustaining 1 beat/cycle while tready=1.
REQ-019 SHALL issue the first read in the cycle after start is sampled and first assert tvalid one cycle after that (start-to-tvalid latency 2).
REQ-020 SHALL form tdata as {8'h00, C,3'b000, Y,3'b000}, where chroma carries Cb on even x and Cr on odd x.
REQ-021 SHALL assert tuser only on beat (x=0,y=0) and tlast only on x=H_ACTIVE-1.
REQ-022 SHALL hold tdata, tuser and tlast stable while tvalid=1 and tready=0, and SHALL never drop tvalid before acceptance.
REQ-023 SHALL keep tvalid low for at least HBLANK cycles between lines when tready=1 (the gap absorbs stalls and does not extend them).
REQ-024 SHALL pulse frame_done and clear busy in the cycle the tlast beat of line V_ACTIVE-1 is accepted.
REQ-025 SHALL accept no new start before the cycle after frame_done (a start coincident with frame_done is ignored).

Reset
REQ-026 SHALL, while rstn=0, set state IDLE, busy=0, frame_done=0, mem_rd_en=0, mem_rd_addr=0, tvalid=0, tuser=0, tlast=0, tdata=0, and empty the FIFO.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame immediately, and SHALL discard any in-flight read data.

Configuration
REQ-028 SHALL, with macro SLANT_STREAM_TX_TPG_EN defined, sample pattern_sel at start; when it is 1, issue no memory reads and generate 8 vertical bars through the same FIFO and timing, with bar=x/(H_ACTIVE/8), Y byte=8'hE0-32*bar and chroma byte 8'h80.
REQ-029 SHALL, without SLANT_STREAM_TX_TPG_EN, omit the pattern_sel port and the generator, and always source from memory.

Verification (H_ACTIVE=4, V_ACTIVE=2, HBLANK=2 unless stated)
REQ-030 SHALL cover: start with tready=1 and memory word at address n = n -> reads 0..7, 8 beats, tuser on beat 0, tlast on beats 3 and 7, exactly 2 idle cycles between lines, frame_done with beat 7.
REQ-031 SHALL cover: tready toggling 1,0,0,1 repeatedly -> no lost, duplicated or reordered beat, tdata stable across stalls, and in-flight reads never exceed FIFO space.
REQ-032 SHALL cover: start pulsed while busy, and again in the frame_done cycle -> both ignored; start one cycle later -> new frame with mem_rd_addr=0.
REQ-033 SHALL cover: mem_rd_data=10'b10101_00011 -> tdata=24'h00A818.
REQ-034 SHALL cover: rstn pulsed low after beat 3 -> all outputs at reset values, and the next start streams a complete frame from address 0.
REQ-035 SHALL cover: with TPG_EN, H_ACTIVE=16 and pattern_sel=1 -> mem_rd_en stays 0, Y bytes E0,E0,C0,C0,...,00,00, and chroma 80.
